// File: rtl/data_memory_arbiter_if.sv
// Bus bundle between the per-core MEM stages, the data memory arbiter and the
// shared single-port DataMemory BRAM.
// Optional feature macro: DMARB_LOCK_EN adds Core_Lock for atomic sequences.
interface data_memory_arbiter_if #(
  parameter int NUM_CORES = 4
);
  logic [NUM_CORES-1:0]    Core_Req;
  logic [NUM_CORES-1:0]    Core_Write;
  logic [32*NUM_CORES-1:0] Core_Address;
  logic [32*NUM_CORES-1:0] Core_WriteData;
  logic [NUM_CORES-1:0]    Core_Ack;
  logic [31:0]             Core_ReadData;
`ifdef DMARB_LOCK_EN
  logic [NUM_CORES-1:0]    Core_Lock;
`endif
  logic                    Mem_En;
  logic [3:0]              Mem_WE;
  logic [9:0]              Mem_Address;
  logic [31:0]             Mem_WriteData;
  logic [31:0]             Mem_ReadData;

  // Arbiter side: serves core requests and drives the BRAM pins.
  modport slave (
    input  Core_Req, Core_Write, Core_Address, Core_WriteData,
    output Core_Ack, Core_ReadData,
    output Mem_En, Mem_WE, Mem_Address, Mem_WriteData,
    input  Mem_ReadData
`ifdef DMARB_LOCK_EN
    , input Core_Lock
`endif
  );

  // Core/memory side: issues requests and supplies BRAM read data.
  modport master (
    output Core_Req, Core_Write, Core_Address, Core_WriteData,
    input  Core_Ack, Core_ReadData,
    input  Mem_En, Mem_WE, Mem_Address, Mem_WriteData,
    output Mem_ReadData
`ifdef DMARB_LOCK_EN
    , output Core_Lock
`endif
  );
endinterface

// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter sharing the single-port data memory BRAM between
// NUM_CORES cores. Each access takes ISSUE (BRAM pins driven) then RESP
// (Ack pulse + read data); under contention accesses run back-to-back.
// Optional feature macro: DMARB_LOCK_EN (locked mode for read-modify-write).
module data_memory_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int IDX_W     = 2
) (
  input logic              Clk,
  input logic              Reset_n,
  data_memory_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t               state, state_next;
  logic [IDX_W-1:0]     rr_ptr, winner, grant_idx, rr_next, cand;
  logic [NUM_CORES-1:0] win_mask, eligible;
  logic                 cap_write, grant, lock_grant;
  int                   idx;
  logic [9:0]           core_word_addr [NUM_CORES];
  logic [31:0]          core_wdata     [NUM_CORES];
`ifdef DMARB_LOCK_EN
  logic                 locked, locked_next;
`endif

  // Slice the flat per-core buses; only byte-address bits [11:2] reach the BRAM.
  for (genvar i = 0; i < NUM_CORES; i++) begin : g_unpack
    assign core_word_addr[i] = bus.Core_Address[32*i+2 +: 10];
    assign core_wdata[i]     = bus.Core_WriteData[32*i +: 32];
  end

  assign win_mask = NUM_CORES'(1) << winner;
  assign rr_next  = (grant_idx == IDX_W'(NUM_CORES-1)) ? '0 : grant_idx + 1'b1;

  // Eligibility, round-robin search from rr_ptr and next-state selection.
  // NOTE: every variable gets a default at the top of an always_comb block so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    eligible   = '0;
    lock_grant = 1'b0;
    grant      = 1'b0;
    grant_idx  = '0;
    idx        = 0;
    cand       = '0;
`ifdef DMARB_LOCK_EN
    locked_next = locked;
`endif
    unique case (state)
      IDLE: begin
        eligible = bus.Core_Req;
`ifdef DMARB_LOCK_EN
        if (locked) begin
          eligible   = bus.Core_Req & win_mask;
          lock_grant = 1'b1;
        end
`endif
      end
      RESP: begin
        // The winner still holds Req during its Ack cycle; do not regrant it.
        eligible = bus.Core_Req & ~win_mask;
`ifdef DMARB_LOCK_EN
        locked_next = bus.Core_Lock[winner];
        if (bus.Core_Lock[winner]) begin
          eligible   = bus.Core_Req & win_mask;
          lock_grant = 1'b1;
        end
`endif
      end
      default: eligible = '0;
    endcase

    for (int i = 0; i < NUM_CORES; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_CORES) idx = idx - NUM_CORES;
      cand = IDX_W'(idx);
      if (!grant && eligible[cand]) begin
        grant     = 1'b1;
        grant_idx = cand;
      end
    end

    unique case (state)
      IDLE:    if (grant) state_next = ISSUE;
      ISSUE:   state_next = RESP;
      RESP:    state_next = grant ? ISSUE : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Grant capture, registered BRAM pins and the one-cycle Ack pulse.
  // NOTE: the captured address/data registers are reset too because they
  // drive BRAM pins directly and must not show stale values after reset.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rr_ptr        <= '0;
      winner        <= '0;
      cap_write     <= 1'b0;
      bus.Core_Ack  <= '0;
      bus.Mem_En    <= 1'b0;
      bus.Mem_WE    <= 4'h0;
      bus.Mem_Address   <= '0;
      bus.Mem_WriteData <= '0;
`ifdef DMARB_LOCK_EN
      locked        <= 1'b0;
`endif
    end else begin
      bus.Mem_En   <= 1'b0;
      bus.Mem_WE   <= 4'h0;
      bus.Core_Ack <= (state == ISSUE) ? win_mask : '0;
      if (grant) begin
        winner            <= grant_idx;
        cap_write         <= bus.Core_Write[grant_idx];
        bus.Mem_En        <= 1'b1;
        bus.Mem_WE        <= {4{bus.Core_Write[grant_idx]}};
        bus.Mem_Address   <= core_word_addr[grant_idx];
        bus.Mem_WriteData <= core_wdata[grant_idx];
        if (!lock_grant) rr_ptr <= rr_next;
      end
`ifdef DMARB_LOCK_EN
      locked <= locked_next;
`endif
    end
  end

  // Read data is forwarded straight from the BRAM during the Ack cycle only.
  assign bus.Core_ReadData = (state == RESP && !cap_write) ? bus.Mem_ReadData : 32'h0;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed self-checking bench for data_memory_arbiter with a behavioural
// BRAM model. The lock scenario is built only when DMARB_LOCK_EN is defined.
module tb_data_memory_arbiter;
  localparam int NUM_CORES = 4;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  logic [31:0] mem [1024];
  logic [31:0] rd_q = '0;

  data_memory_arbiter_if #(.NUM_CORES(NUM_CORES)) bus ();

  data_memory_arbiter #(.NUM_CORES(NUM_CORES), .IDX_W(2)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  always #5 Clk = ~Clk;

  // BRAM: synchronous read, per-byte write enables.
  always @(posedge Clk) begin
    if (bus.Mem_En) begin
      for (int b = 0; b < 4; b++)
        if (bus.Mem_WE[b]) mem[bus.Mem_Address][8*b +: 8] <= bus.Mem_WriteData[8*b +: 8];
      rd_q <= mem[bus.Mem_Address];
    end
  end
  assign bus.Mem_ReadData = rd_q;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_core(input int c, input logic req, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wd);
    bus.Core_Req[c] = req;
    bus.Core_Write[c] = wr;
    bus.Core_Address[32*c +: 32] = addr;
    bus.Core_WriteData[32*c +: 32] = wd;
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic sample;
    @(negedge Clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ack"},   32'(bus.Core_Ack), 32'h0);
    check({tag, "_en"},    32'(bus.Mem_En), 32'h0);
    check({tag, "_we"},    32'(bus.Mem_WE), 32'h0);
    check({tag, "_addr"},  32'(bus.Mem_Address), 32'h0);
    check({tag, "_wdata"}, bus.Mem_WriteData, 32'h0);
    check({tag, "_rdata"}, bus.Core_ReadData, 32'h0);
  endtask

  task automatic pulse_reset;
    tick;
    Reset_n = 1'b0;
    sample;
    Reset_n = 1'b1;
  endtask

`ifdef DMARB_LOCK_EN
  logic [3:0] lk_exp [7] = '{4'h0, 4'h1, 4'h0, 4'h1, 4'h0, 4'h2, 4'h0};
`endif

  initial begin
    bus.Core_Req = '0;
    bus.Core_Write = '0;
    bus.Core_Address = '0;
    bus.Core_WriteData = '0;
`ifdef DMARB_LOCK_EN
    bus.Core_Lock = '0;
`endif
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA500_0000 + i;
    mem[4] = 32'hDEAD_BEEF;

    // Reset state.
    repeat (2) sample;
    check_idle_outputs("reset");
    Reset_n = 1'b1;

    // Core0 read of 0x10; fields changed after capture must be ignored.
    tick;
    set_core(0, 1'b1, 1'b0, 32'h10, 32'h0);
    tick;
    bus.Core_Address[31:0] = 32'h3FC;
    sample;
    check("s1_issue_en", 32'(bus.Mem_En), 32'h1);
    check("s1_issue_addr", 32'(bus.Mem_Address), 32'h4);
    check("s1_issue_we", 32'(bus.Mem_WE), 32'h0);
    check("s1_issue_ack", 32'(bus.Core_Ack), 32'h0);
    tick;
    sample;
    check("s1_resp_ack", 32'(bus.Core_Ack), 32'h1);
    check("s1_resp_rdata", bus.Core_ReadData, 32'hDEAD_BEEF);
    check("s1_resp_en", 32'(bus.Mem_En), 32'h0);
    tick;
    set_core(0, 1'b0, 1'b0, 32'h0, 32'h0);
    sample;
    check("s1_after_ack", 32'(bus.Core_Ack), 32'h0);
    check("s1_after_rdata", bus.Core_ReadData, 32'h0);

    // Core2 writes 0x20, then core1 reads it back through an aliased address.
    tick;
    set_core(2, 1'b1, 1'b1, 32'h20, 32'h1234_5678);
    tick;
    sample;
    check("s2_wr_en", 32'(bus.Mem_En), 32'h1);
    check("s2_wr_we", 32'(bus.Mem_WE), 32'hF);
    check("s2_wr_addr", 32'(bus.Mem_Address), 32'h8);
    check("s2_wr_wdata", bus.Mem_WriteData, 32'h1234_5678);
    tick;
    sample;
    check("s2_wr_ack", 32'(bus.Core_Ack), 32'h4);
    check("s2_wr_rdata", bus.Core_ReadData, 32'h0);
    tick;
    set_core(2, 1'b0, 1'b0, 32'h0, 32'h0);
    set_core(1, 1'b1, 1'b0, 32'hFFFF_F023, 32'h0);
    tick;
    sample;
    check("s2_rd_addr", 32'(bus.Mem_Address), 32'h8);
    check("s2_rd_we", 32'(bus.Mem_WE), 32'h0);
    tick;
    sample;
    check("s2_rd_ack", 32'(bus.Core_Ack), 32'h2);
    check("s2_rd_rdata", bus.Core_ReadData, 32'h1234_5678);
    tick;
    set_core(1, 1'b0, 1'b0, 32'h0, 32'h0);

    // All four cores request reads from reset: Acks at cycles 2,4,6,8.
    pulse_reset;
    for (int i = 0; i < 4; i++) set_core(i, 1'b1, 1'b0, 32'h40 + 4*i, 32'h0);
    for (int c = 1; c <= 9; c++) begin
      @(posedge Clk);
      #1;
      if (c >= 3 && (c % 2) == 1) bus.Core_Req[(c-3)/2] = 1'b0;
      sample;
      if ((c % 2) == 0) begin
        check($sformatf("s3_ack_c%0d", c), 32'(bus.Core_Ack), 32'(1 << (c/2 - 1)));
        check($sformatf("s3_rdata_c%0d", c), bus.Core_ReadData, 32'hA500_0010 + (c/2 - 1));
      end else begin
        check($sformatf("s3_ack_c%0d", c), 32'(bus.Core_Ack), 32'h0);
        if (c <= 7) check($sformatf("s3_addr_c%0d", c), 32'(bus.Mem_Address), 32'(16 + (c-1)/2));
      end
    end

    // Core1 and core3 request continuously: grants alternate 1,3,1,3.
    bus.Core_Req[1] = 1'b1;
    bus.Core_Req[3] = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      tick;
      sample;
      if ((c % 4) == 2) begin
        check($sformatf("s4_ack_c%0d", c), 32'(bus.Core_Ack), 32'h2);
        check($sformatf("s4_rdata_c%0d", c), bus.Core_ReadData, 32'hA500_0011);
      end else if ((c % 4) == 0) begin
        check($sformatf("s4_ack_c%0d", c), 32'(bus.Core_Ack), 32'h8);
        check($sformatf("s4_rdata_c%0d", c), bus.Core_ReadData, 32'hA500_0013);
      end else begin
        check($sformatf("s4_ack_c%0d", c), 32'(bus.Core_Ack), 32'h0);
      end
    end
    check("s5_pre_en", 32'(bus.Mem_En), 32'h1);
    check("s5_pre_addr", 32'(bus.Mem_Address), 32'd17);

    // Reset during ISSUE: outputs clear at once, no Ack, pointer back to 0.
    #1;
    Reset_n = 1'b0;
    #1;
    check_idle_outputs("s5_rst");
    tick;
    check("s5_rst_edge_ack", 32'(bus.Core_Ack), 32'h0);
    sample;
    Reset_n = 1'b1;
    tick;
    sample;
    check("s5_regrant_addr", 32'(bus.Mem_Address), 32'd17);
    tick;
    sample;
    check("s5_regrant_ack", 32'(bus.Core_Ack), 32'h2);
    tick;
    bus.Core_Req[1] = 1'b0;
    sample;
    check("s5_next_addr", 32'(bus.Mem_Address), 32'd19);
    tick;
    sample;
    check("s5_next_ack", 32'(bus.Core_Ack), 32'h8);
    tick;
    bus.Core_Req[3] = 1'b0;
    sample;
    check("s5_idle_ack", 32'(bus.Core_Ack), 32'h0);

`ifdef DMARB_LOCK_EN
    // Core0 locks for two accesses while core1 waits.
    pulse_reset;
    set_core(0, 1'b1, 1'b0, 32'h40, 32'h0);
    set_core(1, 1'b1, 1'b0, 32'h44, 32'h0);
    bus.Core_Lock[0] = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(posedge Clk);
      #1;
      if (c == 3) bus.Core_Lock[0] = 1'b0;
      if (c == 5) bus.Core_Req[0] = 1'b0;
      if (c == 7) bus.Core_Req[1] = 1'b0;
      sample;
      check($sformatf("s6_lock_ack_c%0d", c), 32'(bus.Core_Ack), 32'(lk_exp[c-1]));
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
